mlp_layer_sequencer: RTL and testbench
======================================

// Module: mlp_layer_sequencer
// PURPOSE
//  Sequences one shared dense-layer compute engine through all layers of the jet-tagging MLP.
//  Accepts a frame, issues one start per layer and waits for each done.
//  Steers the ping-pong activation-buffer banks, then presents the result with a valid/ready handshake.
//  Sits between the frame source/softmax sink and the time-multiplexed dense engine plus activation RAMs.
// PARAMETERS
//  NUM_LAYERS     4     dense layers per inference (>=1)
//  LAYER_TIMEOUT  1024  max cycles in WAIT for eng_done before error (>=2)
//  CNT_W          16    frame_count width
// PORTS
//  clk          in   1                    clock, all state on rising edge
//  reset        in   1                    asynchronous, active-high; clears all state
//  in_valid     in   1                    input frame available
//  in_ready     out  1                    sequencer accepts input frame
//  buf_load     out  1                    write input frame into bank 0 (= in_valid & in_ready)
//  eng_start    out  1                    one-cycle start pulse to dense engine
//  eng_layer    out  $clog2(NUM_LAYERS)   layer index (selects weights/bias/sizes)
//  eng_done     in   1                    engine finished current layer (1-cycle pulse)
//  rd_bank      out  1                    activation bank the engine / output reads
//  wr_bank      out  1                    activation bank the engine writes
//  out_valid    out  1                    final activations ready in rd_bank
//  out_ready    in   1                    sink consumes result
//  busy         out  1                    state != IDLE
//  timeout_err  out  1                    sticky, engine failed to finish in time
//  err_clr      in   1                    clears timeout_err, returns ERR -> IDLE
//  frame_count  out  CNT_W                completed frames, wraps at 2^CNT_W
// BEHAVIOUR
//  - Reset values: state=IDLE, layer=0, in_ready=1, out_valid=0, eng_start=0, buf_load=0.
//  - Reset values (cont.): rd_bank=0, wr_bank=0, timeout_err=0, frame_count=0, busy=0, watchdog=0.
//  - States:
//    - IDLE: in_ready=1; on in_valid -> START, layer=0.
//    - START: eng_start=1 for exactly 1 cycle -> WAIT.
//    - WAIT: watchdog counts. On eng_done: if layer==NUM_LAYERS-1 -> OUT, else layer++ -> START.
//    - WAIT timeout: watchdog==LAYER_TIMEOUT-1 without done -> ERR.
//    - OUT: out_valid=1, held stable until out_ready; on handshake frame_count++ -> IDLE.
//    - ERR: timeout_err=1, eng_start never issued; err_clr -> IDLE (timeout_err=0).
//  - Bank steering in START/WAIT: rd_bank=layer[0], wr_bank=~layer[0].
//  - Bank steering in OUT: rd_bank = last wr_bank = ~((NUM_LAYERS-1)&1).
//  - eng_done outside WAIT is ignored; watchdog resets to 0 on entering WAIT.
//  - eng_done arriving on the timeout cycle counts as done (done has priority over timeout).
//  - in_ready is low in every state except IDLE.
//  - out_ready and in_valid both high in OUT: no accept that cycle; accept earliest next cycle in IDLE.
//  - Latency with engine latency L (done L cycles after start):
//    out_valid asserts 1 + NUM_LAYERS*(L+1) cycles after accept.
//  - eng_layer is stable from START through the done cycle.
//  - frame_count wraps from 2^CNT_W-1 to 0 silently.
//  - reset mid-frame: immediate return to IDLE; out_valid and eng_start drop asynchronously.
// STRUCTURE
//  - Package mlp_seq_pkg: typedef enum seq_state_t {IDLE,START,WAIT,OUT,ERR}.
//  - Package mlp_seq_pkg (cont.): NUM_LAYERS default, typedef layer_idx_t.
//  - Sub-module layer_watchdog: clear, enable, LAYER_TIMEOUT parameter, expired output.
//  - Top: FSM and layer counter in one always_ff with async reset; outputs decoded combinationally from state.
// TESTING
//  1. Engine model, done 3 cycles after start; in_valid at cycle 0.
//     -> starts at 1,5,9,13, eng_layer 0..3, out_valid at cycle 17, frame_count=1 after handshake.
//  2. Bank check, same run.
//     -> (rd,wr) = (0,1),(1,0),(0,1),(1,0) per layer; rd_bank=0 during OUT.
//  3. out_ready low 10 cycles, in_valid held high.
//     -> out_valid stays 1, in_ready stays 0; new frame accepted the cycle after the handshake.
//  4. Engine never asserts done, LAYER_TIMEOUT=8.
//     -> ERR 8 cycles into WAIT, timeout_err=1 until err_clr, then in_ready=1.
//  5. reset asserted mid-WAIT of layer 2.
//     -> all outputs at reset values immediately, stray eng_done ignored, next frame starts at layer 0.
//  6. CNT_W=2, run 5 frames.
//     -> frame_count sequence 1,2,3,0,1; spurious eng_done in IDLE causes no state change.

Source files
------------

// File: rtl/mlp_seq_pkg.sv
// Shared state encoding, defaults and bank helper for the MLP layer sequencer.
`timescale 1ns/1ps
package mlp_seq_pkg;

  typedef enum logic [2:0] {IDLE, START, WAIT, OUT, ERR} seq_state_t;

  localparam int NUM_LAYERS_DEFAULT = 4;
  localparam int LAYER_IDX_W = (NUM_LAYERS_DEFAULT > 1) ? $clog2(NUM_LAYERS_DEFAULT) : 1;

  typedef logic [LAYER_IDX_W-1:0] layer_idx_t;

  // The last layer writes bank ~layer[0]; that bank holds the final activations.
  function automatic logic final_bank(input int num_layers);
    return ((num_layers - 1) % 2) == 0;
  endfunction

endpackage

// File: rtl/layer_watchdog.sv
// Per-layer cycle counter; flags expiry when a layer has run LAYER_TIMEOUT cycles.
`timescale 1ns/1ps
module layer_watchdog #(
  parameter int LAYER_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LAYER_TIMEOUT > 1) ? $clog2(LAYER_TIMEOUT) : 1;

  logic [CW-1:0] count;

  assign expired = enable && (count == CW'(LAYER_TIMEOUT - 1));

  // Count saturates at the expiry value; the sequencer leaves WAIT the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Drives one shared dense engine through every MLP layer, steering the ping-pong
// activation banks and handing the final result to the sink via valid/ready.
`timescale 1ns/1ps
module mlp_layer_sequencer
  import mlp_seq_pkg::*;
#(
  parameter int NUM_LAYERS    = NUM_LAYERS_DEFAULT,
  parameter int LAYER_TIMEOUT = 1024,
  parameter int CNT_W         = 16
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  output logic                                             buf_load,
  output logic                                             eng_start,
  output logic [((NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1)-1:0] eng_layer,
  input  logic                                             eng_done,
  output logic                                             rd_bank,
  output logic                                             wr_bank,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic                                             busy,
  output logic                                             timeout_err,
  input  logic                                             err_clr,
  output logic [CNT_W-1:0]                                 frame_count
);

  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
  localparam logic OUT_BANK = final_bank(NUM_LAYERS);

  seq_state_t    state, state_next;
  logic [LW-1:0] layer, layer_next;
  logic          wd_expired;

  layer_watchdog #(
    .LAYER_TIMEOUT(LAYER_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != WAIT),
    .enable (state == WAIT),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      layer       <= '0;
      frame_count <= '0;
    end else begin
      state <= state_next;
      layer <= layer_next;
      if (state == OUT && out_ready) begin
        frame_count <= frame_count + CNT_W'(1);
      end
    end
  end

  // A done on the expiry cycle still completes the layer.
  always_comb begin
    state_next = state;
    layer_next = layer;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = START;
          layer_next = '0;
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        if (eng_done) begin
          if (layer == LAST_LAYER) begin
            state_next = OUT;
          end else begin
            layer_next = layer + LW'(1);
            state_next = START;
          end
        end else if (wd_expired) begin
          state_next = ERR;
        end
      end
      OUT: begin
        if (out_ready) state_next = IDLE;
      end
      ERR: begin
        if (err_clr) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready    = (state == IDLE);
  assign buf_load    = in_valid && (state == IDLE);
  assign eng_start   = (state == START);
  assign eng_layer   = layer;
  assign out_valid   = (state == OUT);
  assign busy        = (state != IDLE);
  assign timeout_err = (state == ERR);

  always_comb begin
    rd_bank = 1'b0;
    wr_bank = 1'b0;
    case (state)
      START, WAIT: begin
        rd_bank = layer[0];
        wr_bank = ~layer[0];
      end
      OUT:     rd_bank = OUT_BANK;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Directed bench for mlp_layer_sequencer with a fixed-latency engine model.
`timescale 1ns/1ps
module tb_mlp_layer_sequencer;
  import mlp_seq_pkg::*;

  localparam int NL = 4;
  localparam int TO = 8;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic err_clr = 1'b0;
  logic stray_done = 1'b0;
  logic in_ready, buf_load, eng_start, eng_done, rd_bank, wr_bank;
  logic out_valid, busy, timeout_err;
  logic [1:0]    eng_layer;
  logic [CW-1:0] frame_count;

  logic model_done = 1'b0;
  int   eng_cnt = 0;
  int   eng_lat = 3;
  bit   engine_on = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  assign eng_done = model_done | stray_done;

  always #5 clk = ~clk;

  mlp_layer_sequencer #(
    .NUM_LAYERS(NL),
    .LAYER_TIMEOUT(TO),
    .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .buf_load(buf_load), .eng_start(eng_start), .eng_layer(eng_layer),
    .eng_done(eng_done), .rd_bank(rd_bank), .wr_bank(wr_bank),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .timeout_err(timeout_err), .err_clr(err_clr), .frame_count(frame_count)
  );

  // Engine raises done for one cycle eng_lat cycles after it sees a start.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (reset) begin
      eng_cnt = 0;
    end else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) model_done = 1'b1;
      end
      if (eng_start && engine_on) eng_cnt = eng_lat;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0; stray_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_cmp++;
    if ({in_ready, out_valid, eng_start, buf_load, rd_bank, wr_bank, timeout_err, busy, eng_layer, frame_count} !== {1'b1, 11'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset_values: got %b want %b",
        {in_ready, out_valid, eng_start, buf_load, rd_bank, wr_bank, timeout_err, busy, eng_layer, frame_count}, {1'b1, 11'b0});
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_frame();
    logic       exp_start;
    logic [1:0] exp_layer;
    do_reset();
    eng_lat = 3; engine_on = 1'b1;
    in_valid = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, buf_load} !== 2'b11) begin
      n_fail++; $display("[TB] FAIL accept_load: got %b want 11", {in_ready, buf_load});
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      if (k <= 16) begin
        exp_start = ((k - 1) % 4) == 0;
        exp_layer = 2'((k - 1) / 4);
        n_cmp++;
        if ({eng_start, eng_layer, rd_bank, wr_bank, in_ready, out_valid} !==
            {exp_start, exp_layer, exp_layer[0], ~exp_layer[0], 1'b0, 1'b0}) begin
          n_fail++;
          $display("[TB] FAIL frame_cycle%0d start/layer/rd/wr/in_ready/out_valid: got %b want %b", k,
            {eng_start, eng_layer, rd_bank, wr_bank, in_ready, out_valid},
            {exp_start, exp_layer, exp_layer[0], ~exp_layer[0], 1'b0, 1'b0});
        end
        @(negedge clk);
      end else begin
        n_cmp++;
        if ({out_valid, rd_bank, eng_start, in_ready} !== 4'b1000) begin
          n_fail++;
          $display("[TB] FAIL out_cycle17 valid/rd/start/in_ready: got %b want 1000",
            {out_valid, rd_bank, eng_start, in_ready});
        end
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if ({out_valid, busy, in_ready, frame_count} !== {1'b0, 1'b0, 1'b1, 2'd1}) begin
      n_fail++;
      $display("[TB] FAIL after_handshake valid/busy/in_ready/count: got %b want 00101",
        {out_valid, busy, in_ready, frame_count});
    end
  endtask

  task automatic test_backpressure();
    int k;
    do_reset();
    eng_lat = 3;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    k = 1;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k !== 17) begin
      n_fail++; $display("[TB] FAIL out_valid_latency: got %0d want 17", k);
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({out_valid, in_ready, buf_load, rd_bank} !== 4'b1000) begin
        n_fail++;
        $display("[TB] FAIL hold%0d valid/in_ready/load/rd: got %b want 1000", i,
          {out_valid, in_ready, buf_load, rd_bank});
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, buf_load} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL no_accept_in_out: got %b want 00", {in_ready, buf_load});
    end
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, buf_load, frame_count} !== {1'b0, 1'b1, 1'b1, 2'd1}) begin
      n_fail++;
      $display("[TB] FAIL next_accept valid/in_ready/load/count: got %b want 01101",
        {out_valid, in_ready, buf_load, frame_count});
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({eng_start, eng_layer} !== 3'b100) begin
      n_fail++; $display("[TB] FAIL next_frame_start: got %b want 100", {eng_start, eng_layer});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    engine_on = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    for (int k = 2; k <= 9; k++) begin
      n_cmp++;
      if ({busy, timeout_err, eng_start} !== 3'b100) begin
        n_fail++;
        $display("[TB] FAIL wait_cycle%0d busy/err/start: got %b want 100", k, {busy, timeout_err, eng_start});
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({timeout_err, busy, in_ready, eng_start} !== 4'b1100) begin
      n_fail++;
      $display("[TB] FAIL err_entry err/busy/in_ready/start: got %b want 1100",
        {timeout_err, busy, in_ready, eng_start});
    end
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({timeout_err, buf_load, eng_start} !== 3'b100) begin
        n_fail++;
        $display("[TB] FAIL err_sticky%0d err/load/start: got %b want 100", i, {timeout_err, buf_load, eng_start});
      end
    end
    in_valid = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_cmp++;
    if ({timeout_err, in_ready, busy} !== 3'b010) begin
      n_fail++; $display("[TB] FAIL err_clear err/in_ready/busy: got %b want 010", {timeout_err, in_ready, busy});
    end
    engine_on = 1'b1;
  endtask

  task automatic test_done_on_timeout_cycle();
    do_reset();
    eng_lat = 8;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    n_cmp++;
    if ({eng_start, eng_layer, timeout_err} !== 4'b1010) begin
      n_fail++;
      $display("[TB] FAIL done_at_limit start/layer/err: got %b want 1010", {eng_start, eng_layer, timeout_err});
    end
    do_reset();
    eng_lat = 9;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    n_cmp++;
    if ({timeout_err, eng_start} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL done_past_limit err/start: got %b want 10", {timeout_err, eng_start});
    end
    eng_lat = 3;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    eng_lat = 3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    n_cmp++;
    if ({busy, eng_layer, eng_start} !== 4'b1100) begin
      n_fail++; $display("[TB] FAIL pre_reset busy/layer/start: got %b want 1100", {busy, eng_layer, eng_start});
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, eng_start, buf_load, rd_bank, wr_bank, timeout_err, busy, eng_layer, frame_count} !== {1'b1, 11'b0}) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got %b want %b",
        {in_ready, out_valid, eng_start, buf_load, rd_bank, wr_bank, timeout_err, busy, eng_layer, frame_count}, {1'b1, 11'b0});
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    n_cmp++;
    if ({busy, in_ready, eng_start} !== 3'b010) begin
      n_fail++; $display("[TB] FAIL stray_done busy/in_ready/start: got %b want 010", {busy, in_ready, eng_start});
    end
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({eng_start, eng_layer} !== 3'b100) begin
      n_fail++; $display("[TB] FAIL restart_layer0: got %b want 100", {eng_start, eng_layer});
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({eng_start, eng_layer} !== 3'b101) begin
      n_fail++; $display("[TB] FAIL restart_layer1: got %b want 101", {eng_start, eng_layer});
    end
  endtask

  task automatic test_frame_wrap();
    int k;
    logic [CW-1:0] exp_fc [5];
    exp_fc = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    eng_lat = 3;
    for (int f = 0; f < 5; f++) begin
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      n_cmp++;
      if ({busy, in_ready} !== 2'b01) begin
        n_fail++; $display("[TB] FAIL idle_stray%0d busy/in_ready: got %b want 01", f, {busy, in_ready});
      end
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 40) begin
        @(negedge clk);
        k++;
      end
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_fail++; $display("[TB] FAIL frame%0d_out_valid: got %b want 1 within 40 cycles", f, out_valid);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_cmp++;
      if (frame_count !== exp_fc[f]) begin
        n_fail++; $display("[TB] FAIL frame%0d_count: got %0d want %0d", f, frame_count, exp_fc[f]);
      end
    end
  endtask

  initial begin
    $display("[TB] starting mlp_layer_sequencer bench");
    test_reset();
    test_single_frame();
    test_backpressure();
    test_timeout();
    test_done_on_timeout_cycle();
    test_reset_mid_frame();
    test_frame_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
